alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Command-side driver for the 4-bit combinational ALU in the TRISC datapath. It accepts an operation and two operands over a valid/ready handshake and drives the ALU's A/B/S0/S1 inputs. It captures R/OVR/Cout into registered result and flag outputs. Multiply is built by sequencing repeated ALU ADD passes, so the controller is the ALU's only master.

Parameters:
DATA_W, 4, operand/result width; must equal the ALU width (4), any other value is unsupported.
CNT_W, 4, width of the multiply iteration counter; must hold max unsigned B (15).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command (high only in IDLE).
cmd_op  input  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 MUL, 101-111 illegal.
cmd_a  input  DATA_W  operand A.
cmd_b  input  DATA_W  operand B (for MUL, an unsigned repeat count).
res_valid  output  1  result/flags valid, held until accepted.
res_ready  input  1  downstream accepts result.
res_data  output  DATA_W  result.
res_z  output  1  result is zero.
res_n  output  1  result MSB.
res_v  output  1  signed overflow.
res_c  output  1  carry / unsigned overflow.
res_err  output  1  illegal opcode.
alu_a  output  DATA_W  to ALU A, registered.
alu_b  output  DATA_W  to ALU B, registered.
alu_s0  output  1  to ALU S0, registered.
alu_s1  output  1  to ALU S1, registered.
alu_r  input  DATA_W  ALU result.
alu_ovr  input  1  ALU overflow.
alu_cout  input  1  ALU carry.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0 except cmd_ready=1.
  - Internal accumulator and counter are 0.
  - Reset mid-operation abandons the operation; no res_valid is produced for it.
- S1/S0 mapping: ADD=00, SUB=01, AND=10, XOR=11. MUL drives 00.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op/a/b.
  - Legal non-MUL op: load alu_a=cmd_a, alu_b=cmd_b and select bits, then go to ISSUE.
  - MUL: set acc=0, cnt=cmd_b, alu_a=0, alu_b=cmd_a, select=ADD. Go to MSTEP if cmd_b!=0, else DONE with result 0.
  - Illegal op: go to DONE with res_data=0, res_err=1, other flags 0.
- ISSUE (1 cycle):
  - ALU inputs are stable.
  - At the clock edge: res_data<=alu_r, res_v<=alu_ovr, res_c<=alu_cout, res_z<=(alu_r==0), res_n<=alu_r[3]. Then go to DONE.
  - AND/XOR force V=C=0 (matches ALU behaviour).
- MSTEP (one cycle per iteration):
  - At each edge: acc<=alu_r, alu_a<=alu_r, cnt<=cnt-1, sticky c|=alu_cout.
  - When cnt==1 at the edge, go to DONE with res_data=final alu_r, res_c=sticky carry, res_v=0, and Z/N from the final result.
- DONE:
  - res_valid=1; outputs stay stable while res_ready=0.
  - On res_ready=1, clear res_valid and go to IDLE. cmd_ready rises the following cycle.
- Latency, counted as accept edge to res_valid:
  - ADD/SUB/AND/XOR: 2 edges.
  - Illegal op, or MUL with B=0: 1 edge.
  - MUL with B=n: n+1 edges.
- Only one command is in flight at a time. cmd_valid while busy is ignored (no accept, no state change).
- Result arithmetic is modulo 2^DATA_W.
- Simultaneous reset and handshake: reset wins.

Optional Feature:
ALU_SEQ_MUL_EN
- Defined: op 100 performs repeated-add multiply as described above.
- Undefined: the MSTEP state, counter and sticky carry are not built. Op 100 is treated as illegal (res_err=1, result 0, latency 1).

Test Plan:
- ADD a=7, b=9 -> alu_s1/s0=00 during ISSUE; res_data=0, Z=1, C=1, V=0; res_valid 2 edges after accept.
- SUB a=4, b=5 -> alu_s0=1; res_data=0xF, N=1, C=0, V=0. Then XOR a=0xA, b=0x6 -> res_data=0xC, V=C=0.
- MUL a=3, b=5 -> 5 MSTEP cycles, alu_a sequence 0,3,6,9,12; res_data=0xF, C=0; res_valid at edge 6. MUL a=5, b=4 -> res_data=4, C=1.
- MUL b=0 and op=110 -> res_valid after 1 edge; MUL gives res_data=0, Z=1, err=0; op=110 gives err=1. Without ALU_SEQ_MUL_EN, MUL gives err=1.
- Backpressure: hold res_ready=0 for 3 cycles -> res_* stable and cmd_ready=0; a cmd_valid pulse meanwhile is not accepted.
- Assert rst_n=0 mid-MUL (a=2, b=9, after 3 steps) -> all outputs 0 immediately, cmd_ready=1 after release, no stale res_valid.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: valid/ready command sequencer that is the sole master of the TRISC 4-bit ALU.
// Optional macro ALU_SEQ_MUL_EN builds the repeated-add multiply (op 100); otherwise op 100 is illegal.
module alu_seq_ctrl #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_z,
    output logic              res_n,
    output logic              res_v,
    output logic              res_c,
    output logic              res_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_s0,
    output logic              alu_s1,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_ovr,
    input  logic              alu_cout
);
`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, ISSUE, DONE, MSTEP} state_t;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sc_q, sc_d;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
`endif
    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, data_q, data_d;
    logic              s0_q, s0_d, s1_q, s1_d;
    logic              z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d, err_q, err_d;

    assign cmd_ready = state_q == IDLE;
    assign res_valid = state_q == DONE;
    assign res_data  = data_q;
    assign res_z     = z_q;
    assign res_n     = n_q;
    assign res_v     = v_q;
    assign res_c     = c_q;
    assign res_err   = err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s0    = s0_q;
    assign alu_s1    = s1_q;

    // State, ALU drive and result registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alu_a_q <= '0;
            alu_b_q <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            data_q  <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt_q   <= '0;
            sc_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            data_q  <= data_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            c_q     <= c_d;
            err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
`endif
        end
    end

    // Next-state: accept in IDLE, capture ALU outputs in ISSUE/MSTEP, hold result in DONE
    always_comb begin
        state_d = state_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        data_d  = data_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
        c_d     = c_q;
        err_d   = err_q;
`ifdef ALU_SEQ_MUL_EN
        cnt_d   = cnt_q;
        sc_d    = sc_q;
`endif
        case (state_q)
            IDLE: if (cmd_valid) begin
                if (!cmd_op[2]) begin
                    alu_a_d = cmd_a;
                    alu_b_d = cmd_b;
                    s1_d    = cmd_op[1];
                    s0_d    = cmd_op[0];
                    err_d   = 1'b0;
                    state_d = ISSUE;
`ifdef ALU_SEQ_MUL_EN
                end else if (cmd_op == 3'b100) begin
                    alu_a_d = '0;
                    alu_b_d = cmd_a;
                    s1_d    = 1'b0;
                    s0_d    = 1'b0;
                    cnt_d   = CNT_W'(cmd_b);
                    sc_d    = 1'b0;
                    data_d  = '0;
                    z_d     = 1'b1;
                    n_d     = 1'b0;
                    v_d     = 1'b0;
                    c_d     = 1'b0;
                    err_d   = 1'b0;
                    state_d = (cmd_b != '0) ? MSTEP : DONE;
`endif
                end else begin
                    data_d  = '0;
                    z_d     = 1'b0;
                    n_d     = 1'b0;
                    v_d     = 1'b0;
                    c_d     = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            ISSUE: begin
                data_d  = alu_r;
                z_d     = alu_r == '0;
                n_d     = alu_r[DATA_W-1];
                v_d     = alu_ovr & ~s1_q;
                c_d     = alu_cout & ~s1_q;
                state_d = DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            MSTEP: begin
                alu_a_d = alu_r;
                cnt_d   = cnt_q - CNT_W'(1);
                sc_d    = sc_q | alu_cout;
                if (cnt_q == CNT_W'(1)) begin
                    data_d  = alu_r;
                    z_d     = alu_r == '0;
                    n_d     = alu_r[DATA_W-1];
                    v_d     = 1'b0;
                    c_d     = sc_q | alu_cout;
                    state_d = DONE;
                end
            end
`endif
            DONE: state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl with a behavioural 4-bit ALU attached
module tb_alu_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, res_valid, res_ready = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_a = '0, cmd_b = '0, res_data, alu_a, alu_b, alu_r;
    logic       res_z, res_n, res_v, res_c, res_err, alu_s0, alu_s1, alu_ovr, alu_cout;
    int         n_checks = 0, n_fail = 0;

    alu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_z(res_z), .res_n(res_n), .res_v(res_v), .res_c(res_c), .res_err(res_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s0(alu_s0), .alu_s1(alu_s1),
        .alu_r(alu_r), .alu_ovr(alu_ovr), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // Behavioural TRISC ALU: ADD, SUB (carry = no borrow), AND, XOR
    always_comb begin
        alu_ovr  = 1'b0;
        alu_cout = 1'b0;
        alu_r    = '0;
        case ({alu_s1, alu_s0})
            2'b00: begin
                {alu_cout, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_ovr = (alu_a[3] == alu_b[3]) && (alu_r[3] != alu_a[3]);
            end
            2'b01: begin
                {alu_cout, alu_r} = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_ovr = (alu_a[3] != alu_b[3]) && (alu_r[3] != alu_a[3]);
            end
            2'b10: alu_r = alu_a & alu_b;
            default: alu_r = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic v, input logic [3:0] d,
                           input logic z, input logic n, input logic ov, input logic c, input logic e);
        chk(tag, {6'd0, res_valid, res_data, res_z, res_n, res_v, res_c, res_err},
                 {6'd0, v, d, z, n, ov, c, e});
    endtask

    task automatic chk_alu(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic s1, input logic s0);
        chk(tag, {6'd0, alu_a, alu_b, alu_s1, alu_s0}, {6'd0, a, b, s1, s0});
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic ack(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk(tag, {14'd0, res_valid, cmd_ready}, 16'b01);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
        chk_res("rst_res", 0, 4'h0, 0, 0, 0, 0, 0);
        chk_alu("rst_alu", 4'h0, 4'h0, 0, 0);
        rst_n = 1'b1;

        send(3'b000, 4'd7, 4'd9);
        chk_alu("add_issue", 4'd7, 4'd9, 0, 0);
        chk("add_busy", {14'd0, res_valid, cmd_ready}, 16'b00);
        @(negedge clk);
        chk_res("add_res", 1, 4'h0, 1, 0, 0, 1, 0);
        ack("add_ack");

        send(3'b001, 4'd4, 4'd5);
        chk_alu("sub_issue", 4'd4, 4'd5, 0, 1);
        @(negedge clk);
        chk_res("sub_res", 1, 4'hF, 0, 1, 0, 0, 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'b000;
        cmd_a     = 4'd1;
        cmd_b     = 4'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_res("bp_hold", 1, 4'hF, 0, 1, 0, 0, 0);
            chk("bp_ready", {15'd0, cmd_ready}, 16'd0);
            @(negedge clk);
        end
        chk_alu("bp_noaccept", 4'd4, 4'd5, 0, 1);
        ack("sub_ack");

        send(3'b011, 4'hA, 4'h6);
        chk_alu("xor_issue", 4'hA, 4'h6, 1, 1);
        @(negedge clk);
        chk_res("xor_res", 1, 4'hC, 0, 1, 0, 0, 0);
        ack("xor_ack");

        send(3'b010, 4'hC, 4'hA);
        chk_alu("and_issue", 4'hC, 4'hA, 1, 0);
        @(negedge clk);
        chk_res("and_res", 1, 4'h8, 0, 1, 0, 0, 0);
        ack("and_ack");

        send(3'b110, 4'h3, 4'h3);
        chk_res("ill_res", 1, 4'h0, 0, 0, 0, 0, 1);
        ack("ill_ack");

`ifdef ALU_SEQ_MUL_EN
        send(3'b100, 4'd3, 4'd5);
        for (int i = 0; i < 5; i++) begin
            chk_alu("mul35_step", 4'(3 * i), 4'd3, 0, 0);
            chk("mul35_busy", {15'd0, res_valid}, 16'd0);
            @(negedge clk);
        end
        chk_res("mul35_res", 1, 4'hF, 0, 1, 0, 0, 0);
        ack("mul35_ack");

        send(3'b100, 4'd5, 4'd4);
        repeat (4) @(negedge clk);
        chk_res("mul54_res", 1, 4'h4, 0, 0, 0, 1, 0);
        ack("mul54_ack");

        send(3'b100, 4'd7, 4'd0);
        chk_res("mul_b0_res", 1, 4'h0, 1, 0, 0, 0, 0);
        ack("mul_b0_ack");
`else
        send(3'b100, 4'd3, 4'd5);
        chk_res("mul_off_res", 1, 4'h0, 0, 0, 0, 0, 1);
        ack("mul_off_ack");
`endif

        send(3'b100, 4'd2, 4'd9);
        repeat (3) @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        chk_alu("mulrst_pre", 4'd6, 4'd2, 0, 0);
`endif
        rst_n = 1'b0;
        #1;
        chk("mulrst_ready", {15'd0, cmd_ready}, 16'd1);
        chk_res("mulrst_res", 0, 4'h0, 0, 0, 0, 0, 0);
        chk_alu("mulrst_alu", 4'h0, 4'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mulrst_idle", {14'd0, res_valid, cmd_ready}, 16'b01);
        end

        send(3'b000, 4'd2, 4'd3);
        @(negedge clk);
        chk_res("post_rst_add", 1, 4'h5, 0, 0, 0, 0, 0);
        ack("post_rst_ack");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
